multi_axis_position_keeper: RTL and testbench

Parametrised, multi-axis successor to the single-XY position keeper. Accepts decoded G-code ops from the processor and tracks absolute/relative mode (G90/G91). It resolves each motion op into a clamped absolute target, hands that target to the motion stage over a valid/ready handshake, and commits the new current position only when motion reports completion. It also supports G92 (set position), G28 (home), per-axis masking and soft-limit clamping with a sticky error flag.

---
 rtl/multi_axis_position_keeper_pkg.sv | 31 +++
 rtl/multi_axis_position_keeper_if.sv | 31 +++
 rtl/multi_axis_position_keeper_axis_target_resolver.sv | 55 +++++
 rtl/multi_axis_position_keeper.sv | 124 ++++++++++++
 tb/tb_multi_axis_position_keeper.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/multi_axis_position_keeper_pkg.sv
// Shared types for the multi-axis position keeper.
//   Op_PKG           : decoded G-code command encoding produced by the processor.
//   MultiAxisPos_PKG : keeper FSM state, default geometry, position/axis-vector types.
package Op_PKG;

  typedef enum logic [3:0] {
    OP_G00 = 4'd0,
    OP_G01 = 4'd1,
    OP_G28 = 4'd2,
    OP_G90 = 4'd3,
    OP_G91 = 4'd4,
    OP_G92 = 4'd5
  } op_cmd_e;

endpackage

package MultiAxisPos_PKG;

  localparam int DEF_NUM_AXES = 3;
  localparam int DEF_POS_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_MOVING
  } state_e;

  typedef logic signed [DEF_POS_BITS-1:0] pos_t;
  typedef pos_t [DEF_NUM_AXES-1:0]        axis_vec_t;

endpackage

// File: rtl/multi_axis_position_keeper_if.sv
// Op and motion handshake bundle for the position keeper.
//   master : op producer / motion stage side (drives op_*, move_ready, move_done)
//   slave  : keeper side (drives op_ready, move_valid, move_target)
// Axis 0 occupies the least significant POS_BITS of every per-axis vector.
interface multi_axis_position_keeper_if #(
  parameter int NUM_AXES = 3,
  parameter int POS_BITS = 16
);
  import Op_PKG::*;

  logic                               op_valid;
  logic                               op_ready;
  op_cmd_e                            op_cmd;
  logic [NUM_AXES-1:0]                op_axis_mask;
  logic [NUM_AXES-1:0][POS_BITS-1:0]  op_arg;
  logic                               move_valid;
  logic                               move_ready;
  logic [NUM_AXES-1:0][POS_BITS-1:0]  move_target;
  logic                               move_done;

  modport master (
    output op_valid, op_cmd, op_axis_mask, op_arg, move_ready, move_done,
    input  op_ready, move_valid, move_target
  );

  modport slave (
    input  op_valid, op_cmd, op_axis_mask, op_arg, move_ready, move_done,
    output op_ready, move_valid, move_target
  );

endinterface

// File: rtl/multi_axis_position_keeper_axis_target_resolver.sv
// Per-axis combinational target resolution.
//   cur_i      : committed position of this axis
//   arg_i      : op argument for this axis
//   mask_i     : axis argument present (for homing: axis selected)
//   absolute_i : G90 mode
//   home_i     : op is G28
//   target_o   : resolved target clamped to [POS_MIN, POS_MAX]
//   clamped_o  : raw value fell outside the soft limits
module axis_target_resolver #(
  parameter int POS_BITS = 16,
  parameter int POS_MIN  = -(2**(POS_BITS-1)),
  parameter int POS_MAX  = 2**(POS_BITS-1)-1
) (
  input  logic [POS_BITS-1:0] cur_i,
  input  logic [POS_BITS-1:0] arg_i,
  input  logic                mask_i,
  input  logic                absolute_i,
  input  logic                home_i,
  output logic [POS_BITS-1:0] target_o,
  output logic                clamped_o
);

  localparam logic signed [POS_BITS:0] MIN_W = (POS_BITS+1)'(POS_MIN);
  localparam logic signed [POS_BITS:0] MAX_W = (POS_BITS+1)'(POS_MAX);

  logic signed [POS_BITS:0] cur_w;
  logic signed [POS_BITS:0] arg_w;
  logic signed [POS_BITS:0] raw;

  // One extra bit so a relative sum saturates at the limits instead of wrapping.
  assign cur_w = {cur_i[POS_BITS-1], cur_i};
  assign arg_w = {arg_i[POS_BITS-1], arg_i};

  always_comb begin
    raw = cur_w;
    if (home_i) begin
      if (mask_i) raw = '0;
    end else if (mask_i) begin
      raw = absolute_i ? arg_w : (cur_w + arg_w);
    end
  end

  always_comb begin
    clamped_o = 1'b0;
    target_o  = raw[POS_BITS-1:0];
    if (raw > MAX_W) begin
      clamped_o = 1'b1;
      target_o  = MAX_W[POS_BITS-1:0];
    end else if (raw < MIN_W) begin
      clamped_o = 1'b1;
      target_o  = MIN_W[POS_BITS-1:0];
    end
  end

endmodule

// File: rtl/multi_axis_position_keeper.sv
// Multi-axis position keeper: tracks G90/G91 mode, resolves motion ops into
// clamped absolute targets, hands them to the motion stage and commits the
// current position only on move_done. Supports G92 and G28.
//   clk, reset (sync, active-high), clk_en (qualifies all updates)
//   bus         : op input handshake and move output handshake (slave modport)
//   cur_pos     : committed current position
//   is_absolute : 1 = G90, 0 = G91
//   limit_err   : sticky, set when any resolved target was clamped
module multi_axis_position_keeper
  import MultiAxisPos_PKG::*;
  import Op_PKG::*;
#(
  parameter int NUM_AXES = 3,
  parameter int POS_BITS = 16,
  parameter int POS_MIN  = -(2**(POS_BITS-1)),
  parameter int POS_MAX  = 2**(POS_BITS-1)-1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clk_en,
  multi_axis_position_keeper_if.slave       bus,
  output logic [NUM_AXES-1:0][POS_BITS-1:0] cur_pos,
  output logic                              is_absolute,
  output logic                              limit_err
);

  state_e                            state_q;
  logic                              op_ready_q;
  logic                              move_valid_q;
  logic [NUM_AXES-1:0][POS_BITS-1:0] move_target_q;
  logic [NUM_AXES-1:0][POS_BITS-1:0] cur_pos_q;
  logic                              is_absolute_q;
  logic                              limit_err_q;

  logic                              is_home;
  logic [NUM_AXES-1:0]               eff_mask;
  logic [NUM_AXES-1:0][POS_BITS-1:0] res_target;
  logic [NUM_AXES-1:0]               res_clamped;

  // G28 with no axis selected homes every axis.
  always_comb begin
    is_home  = (bus.op_cmd == OP_G28);
    eff_mask = bus.op_axis_mask;
    if (is_home && (bus.op_axis_mask == '0)) eff_mask = '1;
  end

  for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
    axis_target_resolver #(
      .POS_BITS (POS_BITS),
      .POS_MIN  (POS_MIN),
      .POS_MAX  (POS_MAX)
    ) u_resolver (
      .cur_i      (cur_pos_q[g]),
      .arg_i      (bus.op_arg[g]),
      .mask_i     (eff_mask[g]),
      .absolute_i (is_absolute_q),
      .home_i     (is_home),
      .target_o   (res_target[g]),
      .clamped_o  (res_clamped[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_ready_q    <= 1'b1;
      move_valid_q  <= 1'b0;
      move_target_q <= '0;
      cur_pos_q     <= '0;
      is_absolute_q <= 1'b1;
      limit_err_q   <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_cmd)
              OP_G90: is_absolute_q <= 1'b1;
              OP_G91: is_absolute_q <= 1'b0;
              OP_G92: begin
                for (int unsigned i = 0; i < NUM_AXES; i++) begin
                  if (bus.op_axis_mask[i]) cur_pos_q[i] <= bus.op_arg[i];
                end
              end
              OP_G00, OP_G01, OP_G28: begin
                move_target_q <= res_target;
                if (|res_clamped) limit_err_q <= 1'b1;
                state_q       <= ST_ISSUE;
                op_ready_q    <= 1'b0;
                move_valid_q  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          if (bus.move_ready) begin
            state_q      <= ST_MOVING;
            move_valid_q <= 1'b0;
          end
        end
        ST_MOVING: begin
          if (bus.move_done) begin
            cur_pos_q  <= move_target_q;
            state_q    <= ST_IDLE;
            op_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          op_ready_q   <= 1'b1;
          move_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.move_valid  = move_valid_q;
  assign bus.move_target = move_target_q;
  assign cur_pos         = cur_pos_q;
  assign is_absolute     = is_absolute_q;
  assign limit_err       = limit_err_q;

endmodule

// File: tb/tb_multi_axis_position_keeper.sv
// Directed bench for multi_axis_position_keeper (3 axes, 16-bit positions).
module tb_multi_axis_position_keeper;
  import Op_PKG::*;

  localparam int NA = 3;
  localparam int PB = 16;

  logic clk;
  logic reset;
  logic clk_en;
  logic [NA-1:0][PB-1:0] cur_pos;
  logic is_absolute;
  logic limit_err;

  int checks;
  int failures;

  multi_axis_position_keeper_if #(.NUM_AXES(NA), .POS_BITS(PB)) bus ();

  multi_axis_position_keeper #(
    .NUM_AXES (NA),
    .POS_BITS (PB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .bus         (bus.slave),
    .cur_pos     (cur_pos),
    .is_absolute (is_absolute),
    .limit_err   (limit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NA*PB-1:0] v3(input int x, input int y, input int z);
    return {16'(z), 16'(y), 16'(x)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input op_cmd_e cmd, input logic [NA-1:0] mask,
                         input int x, input int y, input int z);
    bus.op_valid     = 1'b1;
    bus.op_cmd       = cmd;
    bus.op_axis_mask = mask;
    bus.op_arg       = v3(x, y, z);
    step();
    bus.op_valid     = 1'b0;
    bus.op_axis_mask = '0;
    bus.op_arg       = '0;
  endtask

  task automatic handshake_and_done();
    bus.move_ready = 1'b1;
    step();
    bus.move_ready = 1'b0;
    bus.move_done  = 1'b1;
    step();
    bus.move_done  = 1'b0;
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    clk_en           = 1'b1;
    bus.op_valid     = 1'b0;
    bus.op_cmd       = OP_G00;
    bus.op_axis_mask = '0;
    bus.op_arg       = '0;
    bus.move_ready   = 1'b0;
    bus.move_done    = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset values
    chk("rst_op_ready",    64'(bus.op_ready),    64'd1);
    chk("rst_move_valid",  64'(bus.move_valid),  64'd0);
    chk("rst_move_target", 64'(bus.move_target), 64'd0);
    chk("rst_cur_pos",     64'(cur_pos),         64'd0);
    chk("rst_is_absolute", 64'(is_absolute),     64'd1);
    chk("rst_limit_err",   64'(limit_err),       64'd0);

    // G90, then absolute G01 X=3 Y=-2
    send_op(OP_G90, 3'b000, 0, 0, 0);
    chk("g90_abs", 64'(is_absolute), 64'd1);
    send_op(OP_G01, 3'b011, 3, -2, 77);
    chk("g01a_valid",  64'(bus.move_valid),  64'd1);
    chk("g01a_target", 64'(bus.move_target), 64'(v3(3, -2, 0)));
    chk("g01a_ready",  64'(bus.op_ready),    64'd0);
    chk("g01a_cur",    64'(cur_pos),         64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid",  64'(bus.move_valid),  64'd1);
      chk("stall_target", 64'(bus.move_target), 64'(v3(3, -2, 0)));
    end
    // move_done while still in ISSUE is ignored
    bus.move_done = 1'b1;
    step();
    bus.move_done = 1'b0;
    chk("early_done_cur",   64'(cur_pos),        64'd0);
    chk("early_done_valid", 64'(bus.move_valid), 64'd1);
    bus.move_ready = 1'b1;
    step();
    bus.move_ready = 1'b0;
    chk("moving_valid", 64'(bus.move_valid), 64'd0);
    chk("moving_cur",   64'(cur_pos),        64'd0);
    chk("moving_ready", 64'(bus.op_ready),   64'd0);
    bus.move_done = 1'b1;
    step();
    bus.move_done = 1'b0;
    chk("done_cur",   64'(cur_pos),      64'(v3(3, -2, 0)));
    chk("done_ready", 64'(bus.op_ready), 64'd1);

    // G91, relative X+5
    send_op(OP_G91, 3'b000, 0, 0, 0);
    chk("g91_abs", 64'(is_absolute), 64'd0);
    send_op(OP_G01, 3'b001, 5, 9, 9);
    chk("g01r_target", 64'(bus.move_target), 64'(v3(8, -2, 0)));
    chk("g01r_cur",    64'(cur_pos),         64'(v3(3, -2, 0)));
    handshake_and_done();
    chk("g01r_done", 64'(cur_pos), 64'(v3(8, -2, 0)));

    // G92 Y=100 followed back-to-back by G91
    send_op(OP_G92, 3'b010, 55, 100, 55);
    chk("g92_cur",   64'(cur_pos),        64'(v3(8, 100, 0)));
    chk("g92_valid", 64'(bus.move_valid), 64'd0);
    chk("g92_ready", 64'(bus.op_ready),   64'd1);
    send_op(OP_G90, 3'b000, 0, 0, 0);
    chk("b2b_abs", 64'(is_absolute), 64'd1);
    send_op(OP_G91, 3'b000, 0, 0, 0);
    chk("b2b_rel", 64'(is_absolute), 64'd0);

    // G28 with empty mask homes all axes; then reset while MOVING
    send_op(OP_G28, 3'b000, 0, 0, 0);
    chk("g28_target", 64'(bus.move_target), 64'd0);
    chk("g28_valid",  64'(bus.move_valid),  64'd1);
    chk("g28_cur",    64'(cur_pos),         64'(v3(8, 100, 0)));
    bus.move_ready = 1'b1;
    step();
    bus.move_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mvrst_cur",   64'(cur_pos),         64'd0);
    chk("mvrst_valid", 64'(bus.move_valid),  64'd0);
    chk("mvrst_ready", 64'(bus.op_ready),    64'd1);
    chk("mvrst_abs",   64'(is_absolute),     64'd1);
    chk("mvrst_tgt",   64'(bus.move_target), 64'd0);
    // move_done after reset (IDLE) is ignored
    bus.move_done = 1'b1;
    step();
    bus.move_done = 1'b0;
    chk("idle_done_cur", 64'(cur_pos), 64'd0);

    // G28 with mask Y only: X and Z hold
    send_op(OP_G92, 3'b111, 11, 22, 33);
    send_op(OP_G28, 3'b010, 0, 0, 0);
    chk("g28m_target", 64'(bus.move_target), 64'(v3(11, 0, 33)));
    handshake_and_done();
    chk("g28m_cur", 64'(cur_pos), 64'(v3(11, 0, 33)));

    // Relative overflow saturates at POS_MAX; limit_err is sticky
    send_op(OP_G92, 3'b001, 32760, 0, 0);
    send_op(OP_G91, 3'b000, 0, 0, 0);
    send_op(OP_G01, 3'b001, 100, 0, 0);
    chk("ovf_target", 64'(bus.move_target), 64'(v3(32767, 0, 33)));
    chk("ovf_err",    64'(limit_err),       64'd1);
    handshake_and_done();
    chk("ovf_cur", 64'(cur_pos), 64'(v3(32767, 0, 33)));
    send_op(OP_G01, 3'b001, -7, 0, 0);
    chk("inrange_target", 64'(bus.move_target), 64'(v3(32760, 0, 33)));
    chk("sticky_err",     64'(limit_err),       64'd1);
    handshake_and_done();

    // Relative underflow saturates at POS_MIN
    send_op(OP_G92, 3'b001, -32760, 0, 0);
    send_op(OP_G01, 3'b001, -100, 0, 0);
    chk("unf_target", 64'(bus.move_target), 64'(v3(-32768, 0, 33)));
    handshake_and_done();
    chk("unf_cur", 64'(cur_pos), 64'(v3(-32768, 0, 33)));

    // clk_en low: op_valid not sampled, nothing changes
    clk_en           = 1'b0;
    bus.op_valid     = 1'b1;
    bus.op_cmd       = OP_G01;
    bus.op_axis_mask = 3'b001;
    bus.op_arg       = v3(1, 0, 0);
    step();
    step();
    bus.op_valid     = 1'b0;
    clk_en           = 1'b1;
    chk("cen_ready", 64'(bus.op_ready),   64'd1);
    chk("cen_valid", 64'(bus.move_valid), 64'd0);
    chk("cen_abs",   64'(is_absolute),    64'd0);
    chk("cen_cur",   64'(cur_pos),        64'(v3(-32768, 0, 33)));

    // clk_en low in ISSUE: move_ready not sampled
    send_op(OP_G01, 3'b100, 0, 0, 1);
    chk("cen2_target", 64'(bus.move_target), 64'(v3(-32768, 0, 34)));
    clk_en         = 1'b0;
    bus.move_ready = 1'b1;
    step();
    clk_en         = 1'b1;
    bus.move_ready = 1'b0;
    chk("cen2_valid", 64'(bus.move_valid), 64'd1);
    handshake_and_done();
    chk("cen2_cur", 64'(cur_pos), 64'(v3(-32768, 0, 34)));

    // Unknown command is accepted and dropped
    send_op(op_cmd_e'(4'hE), 3'b111, 5, 5, 5);
    chk("unk_ready", 64'(bus.op_ready),   64'd1);
    chk("unk_valid", 64'(bus.move_valid), 64'd0);
    chk("unk_cur",   64'(cur_pos),        64'(v3(-32768, 0, 34)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
